matrix_stream_reader: RTL and testbench

- Read-side sequencer for the 10x10 matrix memory block.
- On a start pulse it walks a rows x cols sub-matrix, in row-major or column-major (transpose) order.
- Each element is read through the memory's read port and presented on a valid/ready output stream, tagged with its source indices and a last flag.
- It feeds the multiplier datapath: A operands in row order, B operands in column order.

---
 rtl/matrix_stream_reader.sv | 138 +++++++++++++
 tb/tb_matrix_stream_reader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_reader.sv
// rtl/matrix_stream_reader.sv - walks a rows x cols sub-matrix through the memory read port
// and streams each element out with its (row, col) tags and a last flag.
module matrix_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_DIM    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  transpose,
    input  logic [3:0]            num_rows,
    input  logic [3:0]            num_cols,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  en_ReadMat,
    output logic                  en_WriteMat,
    output logic [3:0]            rowAddr,
    output logic [3:0]            colAddr,
    input  logic [DATA_WIDTH-1:0] readData,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [3:0]            out_row,
    output logic [3:0]            out_col,
    output logic                  out_last
);

    typedef enum logic [2:0] {IDLE, REQ, CAP, OUT, FIN} state_t;

    localparam logic [3:0] MAX_D = 4'(MAX_DIM);

    state_t     state, state_nxt;
    logic       tr_q;
    logic [3:0] rows_q, cols_q;
    logic [3:0] r, c;
    logic       err_q;
    logic       dims_bad, last_elem, hs;

    assign dims_bad  = (num_rows == 4'd0) || (num_cols == 4'd0) ||
                       (num_rows > MAX_D) || (num_cols > MAX_D);
    assign last_elem = (r == rows_q - 4'd1) && (c == cols_q - 4'd1);
    assign hs        = out_valid && out_ready;

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        en_ReadMat  = 1'b0;
        en_WriteMat = 1'b0;
        // Indices only move when entering REQ or on start, so they double as addresses.
        rowAddr     = r;
        colAddr     = c;
        case (state)
            IDLE: if (start) state_nxt = dims_bad ? FIN : REQ;
            REQ: begin
                busy       = 1'b1;
                en_ReadMat = 1'b1;
                state_nxt  = CAP;
            end
            CAP: begin
                busy      = 1'b1;
                state_nxt = OUT;
            end
            OUT: begin
                busy = 1'b1;
                if (hs) state_nxt = out_last ? FIN : REQ;
            end
            FIN: begin
                done      = 1'b1;
                err       = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tr_q      <= 1'b0;
            rows_q    <= 4'd0;
            cols_q    <= 4'd0;
            r         <= 4'd0;
            c         <= 4'd0;
            err_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= 4'd0;
            out_col   <= 4'd0;
            out_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    tr_q   <= transpose;
                    rows_q <= num_rows;
                    cols_q <= num_cols;
                    r      <= 4'd0;
                    c      <= 4'd0;
                    err_q  <= dims_bad;
                end
                CAP: begin
                    out_data  <= readData;
                    out_row   <= r;
                    out_col   <= c;
                    out_last  <= last_elem;
                    out_valid <= 1'b1;
                end
                OUT: if (hs) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    if (!out_last) begin
                        if (!tr_q) begin
                            if (c == cols_q - 4'd1) begin
                                c <= 4'd0;
                                r <= r + 4'd1;
                            end else begin
                                c <= c + 4'd1;
                            end
                        end else begin
                            if (r == rows_q - 4'd1) begin
                                r <= 4'd0;
                                c <= c + 4'd1;
                            end else begin
                                r <= r + 4'd1;
                            end
                        end
                    end
                end
                FIN: err_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_stream_reader.sv
// tb/tb_matrix_stream_reader.sv - randomized-ready bench for matrix_stream_reader
// against a queue-based model of the expected element order.
module tb_matrix_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       transpose = 1'b0;
    logic [3:0] num_rows = 4'd0;
    logic [3:0] num_cols = 4'd0;
    logic       busy, done, err, en_ReadMat, en_WriteMat;
    logic [3:0] rowAddr, colAddr;
    logic [7:0] readData = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [3:0] out_row, out_col;
    logic       out_last;

    matrix_stream_reader #(.DATA_WIDTH(8), .MAX_DIM(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .transpose(transpose),
        .num_rows(num_rows), .num_cols(num_cols), .busy(busy), .done(done),
        .err(err), .en_ReadMat(en_ReadMat), .en_WriteMat(en_WriteMat),
        .rowAddr(rowAddr), .colAddr(colAddr), .readData(readData),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16][16];
    always @(posedge clk) if (en_ReadMat) readData <= mem[rowAddr][colAddr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [16:0] exp_q [$];
    logic [16:0] held;
    bit          hold = 0;
    bit          rnd_ready = 0;
    bit          done_seen, err_seen, busy_seen;
    int          rd_cnt, stall_cnt, hs_cnt;
    time         done_time;

    always @(posedge clk) begin
        #1 out_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (en_ReadMat) rd_cnt++;
            if (busy) busy_seen = 1;
            if (err) err_seen = 1;
            if (done && !done_seen) begin
                done_seen = 1;
                done_time = $time;
            end
            if (!out_valid) begin
                hold = 0;
                if (out_last) check("last_without_valid", {31'd0, out_last}, 32'd0);
            end else begin
                if (hold) check("stall_stable", {15'd0, out_data, out_row, out_col, out_last}, {15'd0, held});
                if (!out_ready) begin
                    hold = 1;
                    held = {out_data, out_row, out_col, out_last};
                    stall_cnt++;
                end else begin
                    hold = 0;
                    hs_cnt++;
                    check("write_en_low", {31'd0, en_WriteMat}, 32'd0);
                    if (exp_q.size() == 0) check("unexpected_elem", 32'd1, 32'd0);
                    else check("elem", {15'd0, out_data, out_row, out_col, out_last}, {15'd0, exp_q.pop_front()});
                end
            end
        end
    end

    function automatic logic [30:0] all_outs();
        return {busy, done, err, en_ReadMat, en_WriteMat, rowAddr, colAddr, out_valid,
                out_data, out_row, out_col, out_last};
    endfunction

    task automatic build_expected(input int nr, input int nc, input bit tr);
        int n = nr * nc;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            int rr = tr ? (k % nr) : (k / nc);
            int cc = tr ? (k / nr) : (k % nc);
            logic [7:0] d = 8'((16 * rr + cc) & 255);
            exp_q.push_back({d, 4'(rr), 4'(cc), 1'(k == n - 1)});
        end
    endtask

    task automatic clear_counters();
        done_seen = 0; err_seen = 0; busy_seen = 0;
        rd_cnt = 0; stall_cnt = 0; hs_cnt = 0; hold = 0;
    endtask

    task automatic pulse_start(input int nr, input int nc, input bit tr, output time t_edge);
        @(posedge clk);
        #2;
        start = 1; transpose = tr; num_rows = 4'(nr); num_cols = 4'(nc);
        @(posedge clk);
        t_edge = $time;
        #2 start = 0;
    endtask

    task automatic run(input int nr, input int nc, input bit tr, input bit rnd, input bit mid);
        time tE;
        int  k;
        bit  bad = (nr == 0) || (nc == 0) || (nr > 10) || (nc > 10);
        int  n = bad ? 0 : nr * nc;
        if (bad) exp_q.delete();
        else build_expected(nr, nc, tr);
        rnd_ready = rnd;
        clear_counters();
        pulse_start(nr, nc, tr, tE);
        for (int i = 0; i < 5000 && !done_seen; i++) begin
            if (mid && i == 10) begin
                start = 1; transpose = ~tr; num_rows = 4'd1; num_cols = 4'd1;
            end
            if (mid && i == 11) start = 0;
            @(posedge clk);
            #2;
        end
        start = 0;
        check($sformatf("done_%0dx%0d", nr, nc), {31'd0, done_seen}, 32'd1);
        check($sformatf("err_%0dx%0d", nr, nc), {31'd0, err_seen}, {31'd0, bad});
        check($sformatf("busy_seen_%0dx%0d", nr, nc), {31'd0, busy_seen}, {31'd0, !bad});
        check($sformatf("reads_%0dx%0d", nr, nc), rd_cnt, n);
        check($sformatf("remaining_%0dx%0d", nr, nc), exp_q.size(), 0);
        k = int'((done_time - tE - 5) / 10) + 1;
        if (done_seen) check($sformatf("done_latency_%0dx%0d", nr, nc), k, 3 * n + 1 + stall_cnt);
        rnd_ready = 0;
    endtask

    initial begin
        time tE;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                mem[r][c] = 8'((16 * r + c) & 255);

        clear_counters();
        #12;
        check("reset_outputs", {1'b0, all_outs()}, 32'd0);
        @(negedge clk);
        rst_n = 1;

        run(2, 3, 0, 0, 0);
        run(2, 3, 1, 0, 0);
        run(10, 10, 0, 1, 0);
        run(3, 4, 1, 1, 1);
        run(0, 5, 0, 0, 0);
        run(4, 11, 0, 0, 0);
        run(1, 1, 0, 1, 0);
        for (int t = 0; t < 3; t++)
            run($urandom_range(1, 10), $urandom_range(1, 10), 1'($urandom_range(1)), 1, 0);

        build_expected(3, 4, 0);
        rnd_ready = 1;
        clear_counters();
        pulse_start(3, 4, 0, tE);
        for (int i = 0; i < 500 && !(hs_cnt >= 4 && out_valid); i++) begin
            @(posedge clk);
            #2;
        end
        check("reached_elem4", {31'd0, out_valid}, 32'd1);
        rst_n = 0;
        #1 check("midrun_reset_outputs", {1'b0, all_outs()}, 32'd0);
        exp_q.delete();
        rnd_ready = 0;
        clear_counters();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        repeat (4) @(posedge clk);
        #2 check("no_done_after_reset", {31'd0, done_seen}, 32'd0);
        run(2, 2, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
